udp_regbus_arbiter: RTL and testbench

Shares the registered UDP register-bus port (active-low `wr_n`/`rd_n` strobes, 16-bit `addr`/`wdata`, returned `rdata`) between `N_REQ` requesters, e.g. the Avalon host bridge and internal config/stat engines. It grants the bus round-robin and issues exactly one single-cycle strobe per transaction. For reads it waits a fixed latency, captures `rdata`, and returns it with a one-cycle acknowledge.

---
 rtl/udp_regbus_pkg.sv | 15 +
 rtl/udp_regbus_arbiter_rr_arbiter.sv | 30 +++
 rtl/udp_regbus_arbiter.sv | 159 +++++++++++++++
 tb/tb_udp_regbus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_regbus_pkg.sv
// Shared types and defaults for the UDP register-bus arbiter.
package udp_regbus_pkg;

  localparam int unsigned AW_DEF    = 16;
  localparam int unsigned DW_DEF    = 16;
  localparam int unsigned LAT_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

endpackage

// File: rtl/udp_regbus_arbiter_rr_arbiter.sv
// Combinational one-hot round-robin pick; search starts just after ptr_i.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned PW    = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_c_o,
  output logic [PW-1:0]    idx_c_o,
  output logic             any_c_o
);

  logic [PW-1:0] cand;

  always_comb begin
    gnt_c_o = '0;
    idx_c_o = '0;
    any_c_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = PW'((32'(ptr_i) + k) % N_REQ);
      if (!any_c_o && req_i[cand]) begin
        gnt_c_o[cand] = 1'b1;
        idx_c_o       = cand;
        any_c_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_regbus_arbiter.sv
// Round-robin sharing of the registered UDP register bus: one strobe per
// transaction, fixed-latency read capture, one-cycle acknowledge.
module udp_regbus_arbiter
  import udp_regbus_pkg::*;
#(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [N_REQ-1:0]    req_we_i,
  input  logic [N_REQ*AW-1:0] req_addr_i,
  input  logic [N_REQ*DW-1:0] req_wdata_i,
  output logic [N_REQ-1:0]    ack_o,
  output logic [DW-1:0]       ack_rdata_o,
  output logic [N_REQ-1:0]    grant_o,
  output logic                wr_n_o,
  output logic                rd_n_o,
  output logic [AW-1:0]       addr_o,
  output logic [DW-1:0]       wdata_o,
  input  logic [DW-1:0]       rdata_i
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e               state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 wr_n_q, wr_n_d;
  logic                 rd_n_q, rd_n_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [DW-1:0]        ack_rdata_q, ack_rdata_d;

  logic [N_REQ-1:0]     pick_c;
  logic [PW-1:0]        pick_idx_c;
  logic                 pick_any_c;
  logic                 pick_we_c;
  logic [AW-1:0]        pick_addr_c;
  logic [DW-1:0]        pick_wdata_c;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_c_o (pick_c),
    .idx_c_o (pick_idx_c),
    .any_c_o (pick_any_c)
  );

  // Winner's payload, selected by the one-hot pick
  always_comb begin
    pick_addr_c  = '0;
    pick_wdata_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_c[i]) begin
        pick_addr_c  = req_addr_i[i*AW +: AW];
        pick_wdata_c = req_wdata_i[i*DW +: DW];
      end
    end
  end

  assign pick_we_c = |(pick_c & req_we_i);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ack_d       = '0;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    wr_n_d      = 1'b1;
    rd_n_d      = 1'b1;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ack_rdata_d = ack_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any_c) begin
          state_d = ST_STROBE;
          grant_d = pick_c;
          ptr_d   = pick_idx_c;
          addr_d  = pick_addr_c;
          wdata_d = pick_wdata_c;
          wr_n_d  = ~pick_we_c;
          rd_n_d  = pick_we_c;
        end
      end
      ST_STROBE: begin
        if (!wr_n_q) begin
          state_d = ST_ACK;
          ack_d   = grant_q;
        end else if (RD_LAT == 0) begin
          ack_rdata_d = rdata_i;
          state_d     = ST_ACK;
          ack_d       = grant_q;
        end else begin
          cnt_d   = LAT_CNT_W'(RD_LAT - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          ack_rdata_d = rdata_i;
          state_d     = ST_ACK;
          ack_d       = grant_q;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      ST_ACK: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      ack_q       <= '0;
      ptr_q       <= PW'(N_REQ - 1);
      cnt_q       <= '0;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      ack_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ack_rdata_q <= ack_rdata_d;
    end
  end

  assign ack_o       = ack_q;
  assign ack_rdata_o = ack_rdata_q;
  assign grant_o     = grant_q;
  assign wr_n_o      = wr_n_q;
  assign rd_n_o      = rd_n_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;

endmodule

// File: tb/tb_udp_regbus_arbiter.sv
// Bench for udp_regbus_arbiter: transaction-schedule model checked every cycle,
// directed scenarios with literal expectations, and a read-latency sweep.
module tb_udp_regbus_arbiter;

  localparam int N   = 2;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0, req_we = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  ack, grant;
  logic [15:0] ack_rdata, addr, wdata;
  logic [15:0] rdata = 16'hDEAD;
  logic        wr_n, rd_n;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  udp_regbus_arbiter #(.N_REQ(2), .AW(16), .DW(16), .RD_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .ack_o(ack),
    .ack_rdata_o(ack_rdata), .grant_o(grant), .wr_n_o(wr_n), .rd_n_o(rd_n),
    .addr_o(addr), .wdata_o(wdata), .rdata_i(rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Register bank: data valid the cycle after the read strobe, junk otherwise
  function automatic logic [15:0] bank_val(input logic [15:0] a);
    return (a == 16'h0020) ? 16'h1234 : (a ^ 16'h5A5A);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) rdata <= 16'hDEAD;
    else     rdata <= !rd_n ? bank_val(addr) : 16'hDEAD;
  end

  // Model: schedules each granted transaction as absolute cycle numbers
  bit          m_act = 1'b0, m_we = 1'b0, m_found;
  int          m_owner = 0, m_start = 0, m_ackc = 0, m_cap = 0, m_last = N - 1, m_cand;
  logic [15:0] m_addr = '0, m_wdata = '0, m_cap_val = '0, m_last_rd = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 1'b0; m_last = N - 1; m_addr = '0; m_wdata = '0;
      m_cap_val = '0; m_last_rd = '0;
    end else begin
      if (m_act && cyc == m_cap) m_cap_val = rdata;
      if (m_act && cyc == m_ackc) begin
        if (!m_we) m_last_rd = m_cap_val;
        m_act = 1'b0;
      end else if (!m_act && req != 2'b00) begin
        m_found = 1'b0;
        for (int off = 1; off <= N; off++) begin
          m_cand = (m_last + off) % N;
          if (!m_found && req[m_cand]) begin
            m_owner = m_cand;
            m_found = 1'b1;
          end
        end
        m_last  = m_owner;
        m_act   = 1'b1;
        m_we    = req_we[m_owner];
        m_start = cyc + 1;
        m_cap   = cyc + 1 + LAT;
        m_ackc  = m_we ? cyc + 2 : cyc + 2 + LAT;
        m_addr  = req_addr[m_owner*16 +: 16];
        m_wdata = req_wdata[m_owner*16 +: 16];
      end
    end
  end

  logic [1:0]  e_grant, e_ack;
  logic        e_wr_n, e_rd_n, in_t;
  logic [15:0] e_ard;

  always @(negedge clk) begin
    in_t    = m_act && cyc >= m_start && cyc <= m_ackc;
    e_grant = in_t ? (2'b01 << m_owner) : 2'b00;
    e_ack   = (m_act && cyc == m_ackc) ? (2'b01 << m_owner) : 2'b00;
    e_wr_n  = !(m_act && cyc == m_start && m_we);
    e_rd_n  = !(m_act && cyc == m_start && !m_we);
    e_ard   = (m_act && cyc == m_ackc && !m_we) ? m_cap_val : m_last_rd;
    chk("m_grant", 32'(grant), 32'(e_grant));
    chk("m_ack", 32'(ack), 32'(e_ack));
    chk("m_wr_n", 32'(wr_n), 32'(e_wr_n));
    chk("m_rd_n", 32'(rd_n), 32'(e_rd_n));
    chk("m_ack_rdata", 32'(ack_rdata), 32'(e_ard));
    chk("m_addr", 32'(addr), 32'(m_addr));
    chk("m_wdata", 32'(wdata), 32'(m_wdata));
  end

  // Latency sweep instances, fed a free-running counter as read data
  logic [15:0] sw_cnt = '0;
  logic [1:0]  sw_req [3];
  logic [1:0]  sw_ack [3];
  logic [1:0]  sw_grant [3];
  logic [15:0] sw_ard [3];
  logic [15:0] sw_addr [3];
  logic [15:0] sw_wdata [3];
  logic        sw_wr_n [3];
  logic        sw_rd_n [3];
  int          lats [3] = '{0, 3, 7};

  always @(posedge clk) sw_cnt <= sw_cnt + 16'd1;

  udp_regbus_arbiter #(.N_REQ(2), .AW(16), .DW(16), .RD_LAT(0)) dut_l0 (
    .clk_i(clk), .rst_i(rst), .req_i(sw_req[0]), .req_we_i(2'b00),
    .req_addr_i({16'h0000, 16'h0040}), .req_wdata_i(32'h0), .ack_o(sw_ack[0]),
    .ack_rdata_o(sw_ard[0]), .grant_o(sw_grant[0]), .wr_n_o(sw_wr_n[0]),
    .rd_n_o(sw_rd_n[0]), .addr_o(sw_addr[0]), .wdata_o(sw_wdata[0]), .rdata_i(sw_cnt)
  );
  udp_regbus_arbiter #(.N_REQ(2), .AW(16), .DW(16), .RD_LAT(3)) dut_l3 (
    .clk_i(clk), .rst_i(rst), .req_i(sw_req[1]), .req_we_i(2'b00),
    .req_addr_i({16'h0000, 16'h0040}), .req_wdata_i(32'h0), .ack_o(sw_ack[1]),
    .ack_rdata_o(sw_ard[1]), .grant_o(sw_grant[1]), .wr_n_o(sw_wr_n[1]),
    .rd_n_o(sw_rd_n[1]), .addr_o(sw_addr[1]), .wdata_o(sw_wdata[1]), .rdata_i(sw_cnt)
  );
  udp_regbus_arbiter #(.N_REQ(2), .AW(16), .DW(16), .RD_LAT(7)) dut_l7 (
    .clk_i(clk), .rst_i(rst), .req_i(sw_req[2]), .req_we_i(2'b00),
    .req_addr_i({16'h0000, 16'h0040}), .req_wdata_i(32'h0), .ack_o(sw_ack[2]),
    .ack_rdata_o(sw_ard[2]), .grant_o(sw_grant[2]), .wr_n_o(sw_wr_n[2]),
    .rd_n_o(sw_rd_n[2]), .addr_o(sw_addr[2]), .wdata_o(sw_wdata[2]), .rdata_i(sw_cnt)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  int          got_t [3];
  logic [15:0] got_d [3];
  logic [15:0] v0;

  initial begin
    for (int j = 0; j < 3; j++) sw_req[j] = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_n", 32'(wr_n), 32'h1);
    chk("rst_rd_n", 32'(rd_n), 32'h1);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_addr", 32'(addr), 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single write from requester 0
    @(posedge clk); #1;
    req = 2'b01; req_we = 2'b01; req_addr[15:0] = 16'h0010; req_wdata[15:0] = 16'hA5A5;
    @(negedge clk);
    @(negedge clk);
    chk("wr_strobe", 32'(wr_n), 32'h0);
    chk("wr_no_rd", 32'(rd_n), 32'h1);
    chk("wr_addr", 32'(addr), 32'h0010);
    chk("wr_wdata", 32'(wdata), 32'hA5A5);
    @(negedge clk);
    chk("wr_ack", 32'(ack), 32'h1);
    chk("wr_strobe_off", 32'(wr_n), 32'h1);
    req = 2'b00;
    repeat (2) @(negedge clk);

    // Single read from requester 1
    @(posedge clk); #1;
    req = 2'b10; req_we = 2'b00; req_addr[31:16] = 16'h0020;
    @(negedge clk);
    @(negedge clk);
    chk("rd_strobe", 32'(rd_n), 32'h0);
    chk("rd_no_wr", 32'(wr_n), 32'h1);
    chk("rd_addr", 32'(addr), 32'h0020);
    @(negedge clk);
    @(negedge clk);
    chk("rd_ack", 32'(ack), 32'h2);
    chk("rd_data", 32'(ack_rdata), 32'h1234);
    req = 2'b00;
    repeat (2) @(negedge clk);

    // Contention: both held, writes alternate 0,1,0,1 every 3 cycles
    @(posedge clk); #1;
    req = 2'b11; req_we = 2'b11;
    req_addr = {16'h0200, 16'h0100}; req_wdata = {16'h2222, 16'h1111};
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("cont_grant", 32'(grant), (n % 2 == 0) ? 32'h1 : 32'h2);
      chk("cont_strobe", 32'(wr_n), 32'h0);
      chk("cont_addr", 32'(addr), (n % 2 == 0) ? 32'h0100 : 32'h0200);
      if (n < 3) repeat (2) @(negedge clk);
    end
    @(negedge clk);
    chk("cont_last_ack", 32'(ack), 32'h2);
    req = 2'b00;
    repeat (2) @(negedge clk);

    // Requester drops req during the strobe cycle of a write
    @(posedge clk); #1;
    req = 2'b01; req_we = 2'b01; req_addr[15:0] = 16'h0050; req_wdata[15:0] = 16'hBEEF;
    @(negedge clk);
    @(negedge clk);
    chk("drop_strobe", 32'(wr_n), 32'h0);
    req = 2'b00;
    @(negedge clk);
    chk("drop_ack", 32'(ack), 32'h1);
    chk("drop_strobe_off", 32'(wr_n), 32'h1);
    @(negedge clk);
    chk("drop_idle", 32'(grant), 32'h0);
    repeat (2) @(negedge clk);

    // Reset while rd_n is low
    @(posedge clk); #1;
    req = 2'b01; req_we = 2'b00; req_addr[15:0] = 16'h0060;
    @(negedge clk);
    @(negedge clk);
    chk("rr_strobe", 32'(rd_n), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("rr_rd_n", 32'(rd_n), 32'h1);
    chk("rr_grant", 32'(grant), 32'h0);
    chk("rr_addr", 32'(addr), 32'h0);
    chk("rr_ack_rdata", 32'(ack_rdata), 32'h0);
    req = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    req = 2'b11; req_we = 2'b11; req_addr = {16'h0AB0, 16'h0CD0};
    @(negedge clk);
    @(negedge clk);
    chk("rr_first_grant", 32'(grant), 32'h1);
    chk("rr_first_addr", 32'(addr), 32'h0CD0);
    @(negedge clk);
    chk("rr_first_ack", 32'(ack), 32'h1);
    req = 2'b00;
    repeat (3) @(negedge clk);

    // Read-latency sweep
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      sw_req[j] = 2'b01;
      got_t[j]  = -1;
      got_d[j]  = '0;
    end
    v0 = sw_cnt;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      if (t == 1) begin
        for (int j = 0; j < 3; j++) begin
          chk("sw_rd_n", 32'(sw_rd_n[j]), 32'h0);
          chk("sw_wr_n", 32'(sw_wr_n[j]), 32'h1);
          chk("sw_grant", 32'(sw_grant[j]), 32'h1);
          chk("sw_addr", 32'(sw_addr[j]), 32'h0040);
          chk("sw_wdata", 32'(sw_wdata[j]), 32'h0);
          sw_req[j] = 2'b00;
        end
      end
      for (int j = 0; j < 3; j++) begin
        if (got_t[j] < 0 && sw_ack[j] != 2'b00) begin
          got_t[j] = t;
          got_d[j] = sw_ard[j];
          chk("sw_ack_onehot", 32'(sw_ack[j]), 32'h1);
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      chk("sw_ack_cycle", 32'(got_t[j]), 32'(2 + lats[j]));
      chk("sw_rdata", 32'(got_d[j]), 32'(v0 + 16'(1 + lats[j])));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
